// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates active-low column strobes, debounces whole-scan
// results, and feeds accepted digit keys into an eight-digit shift display.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [31:0] digits
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);
  localparam logic [31:0]   BLANK    = 32'hAAAA_AAAA;

  typedef enum logic [1:0] {RES_NONE = 2'd0, RES_KEY = 2'd1, RES_MULTI = 2'd2} res_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRESSED = 2'd1, S_LOCKED = 2'd2} state_e;

  function automatic logic [3:0] key_map(input logic [3:0] rc);
    case (rc)
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  4'hF: key_map = 4'hD;
      default: key_map = 4'h0;
    endcase
  endfunction

  function automatic logic [2:0] low_count(input logic [3:0] r);
    low_count = {2'b00, ~r[0]} + {2'b00, ~r[1]} + {2'b00, ~r[2]} + {2'b00, ~r[3]};
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] r);
    if (!r[0])      first_low = 2'd0;
    else if (!r[1]) first_low = 2'd1;
    else if (!r[2]) first_low = 2'd2;
    else            first_low = 2'd3;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] c);
    case (c)
      4'b1110: col_index = 2'd0;
      4'b1101: col_index = 2'd1;
      4'b1011: col_index = 2'd2;
      4'b0111: col_index = 2'd3;
      default: col_index = 2'd0;
    endcase
  endfunction

  logic [3:0]    row_m_q, row_s_q;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    col_q, col_d;
  logic [1:0]    acc_n_q, acc_n_d;
  logic [3:0]    acc_code_q, acc_code_d;
  res_e          res_q, res_d, res_new_s;
  logic [3:0]    rcode_q, rcode_d, code_new_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          eval_q, eval_d;
  state_e        state_q, state_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic [31:0]   digits_q, digits_d;
  logic [2:0]    hits_s, sum_s;
  logic [1:0]    col_idx_s;
  logic [3:0]    code_s;
  logic          stable_s;

  // Column timing, per-scan hit accumulation and debounce counting.
  always_comb begin
    tmr_d      = tmr_q;
    col_d      = col_q;
    acc_n_d    = acc_n_q;
    acc_code_d = acc_code_q;
    res_d      = res_q;
    rcode_d    = rcode_q;
    cnt_d      = cnt_q;
    eval_d     = 1'b0;
    res_new_s  = RES_NONE;
    code_new_s = 4'h0;
    col_idx_s  = col_index(col_q);
    hits_s     = low_count(row_s_q);
    sum_s      = {1'b0, acc_n_q} + hits_s;
    code_s     = (hits_s != 3'd0) ? key_map({first_low(row_s_q), col_idx_s}) : acc_code_q;
    if (tmr_q == TMR_LAST) begin
      tmr_d = '0;
      col_d = {col_q[2:0], col_q[3]};
      if (col_idx_s == 2'd3) begin
        acc_n_d    = 2'd0;
        acc_code_d = 4'h0;
        if (sum_s == 3'd0) begin
          res_new_s = RES_NONE;
        end else if (sum_s == 3'd1) begin
          res_new_s  = RES_KEY;
          code_new_s = code_s;
        end else begin
          res_new_s = RES_MULTI;
        end
        if ((res_new_s == res_q) && (code_new_s == rcode_q)) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end else begin
          cnt_d = CW'(1);
        end
        res_d   = res_new_s;
        rcode_d = code_new_s;
        eval_d  = 1'b1;
      end else begin
        acc_n_d    = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
        acc_code_d = code_s;
      end
    end else begin
      tmr_d = tmr_q + TW'(1);
    end
  end

  // Debounce FSM: accepts a press only from IDLE, locks out rolls and multi-key presses.
  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    digits_d    = digits_q;
    stable_s    = eval_q && (cnt_q == CNT_MAX);
    case (state_q)
      S_IDLE: begin
        if (stable_s && (res_q == RES_KEY)) begin
          state_d     = S_PRESSED;
          key_code_d  = rcode_q;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          if (rcode_q <= 4'd9)       digits_d = {digits_q[27:0], rcode_q};
          else if (rcode_q == 4'hC)  digits_d = BLANK;
          else                       digits_d = digits_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESSED: begin
        if (stable_s && (res_q == RES_NONE)) begin
          state_d    = S_IDLE;
          key_held_d = 1'b0;
        end else if (stable_s && ((res_q == RES_MULTI) ||
                                  ((res_q == RES_KEY) && (rcode_q != key_code_q)))) begin
          state_d    = S_LOCKED;
          key_held_d = 1'b0;
        end else begin
          state_d = S_PRESSED;
        end
      end
      S_LOCKED: begin
        if (stable_s && (res_q == RES_NONE)) state_d = S_IDLE;
        else                                 state_d = S_LOCKED;
      end
      default: begin
        state_d    = S_IDLE;
        key_held_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards all scan and debounce progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m_q     <= 4'b1111;
      row_s_q     <= 4'b1111;
      tmr_q       <= '0;
      col_q       <= 4'b1110;
      acc_n_q     <= 2'd0;
      acc_code_q  <= 4'h0;
      res_q       <= RES_NONE;
      rcode_q     <= 4'h0;
      cnt_q       <= '0;
      eval_q      <= 1'b0;
      state_q     <= S_IDLE;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      digits_q    <= BLANK;
    end else begin
      row_m_q     <= row;
      row_s_q     <= row_m_q;
      tmr_q       <= tmr_d;
      col_q       <= col_d;
      acc_n_q     <= acc_n_d;
      acc_code_q  <= acc_code_d;
      res_q       <= res_d;
      rcode_q     <= rcode_d;
      cnt_q       <= cnt_d;
      eval_q      <= eval_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      digits_q    <= digits_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives the rows from the column
// strobes, and each step compares outputs against hand-computed values.
module tb_keypad_scanner;

  localparam int SD     = 4;
  localparam int DS     = 2;
  localparam int SCAN   = 4 * SD;
  localparam int MAXLAT = (DS + 1) * 4 * SD + 3;
  localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K4 = 4, K5 = 5, K6 = 6;
  localparam int K7 = 8, K8 = 9, KC = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_held;
  logic [31:0] digits;
  logic [15:0] keys = 16'h0000;
  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  int          base;
  int          lat;
  logic [3:0]  pat [4];

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .digits(digits)
  );

  // keys[r*4+c] pressed pulls row r low while column c is strobed
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk) if (key_valid === 1'b1) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  task automatic wait_pulse(input string tag, output int l);
    int found;
    found = 0;
    l = 0;
    for (int i = 1; i <= MAXLAT; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        found = 1;
        l = i;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
    if (found == 1) begin
      @(negedge clk);
      chk({tag, "_one_cycle"}, 32'(key_valid), 32'd0);
    end
  endtask

  task automatic align_scan();
    int ok;
    ok = 0;
    for (int i = 0; i < 4 * SCAN; i++) begin
      @(negedge clk);
      if (col === 4'b0111) begin ok = 1; break; end
    end
    for (int i = 0; i < 4 * SCAN && ok == 1; i++) begin
      @(negedge clk);
      if (col === 4'b1110) begin ok = 2; break; end
    end
    chk("align_scan", 32'(ok), 32'd2);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk({tag, "_col"}, 32'(col), 32'h0000_000E);
    chk({tag, "_code"}, 32'(key_code), 32'h0);
    chk({tag, "_held"}, 32'(key_held), 32'h0);
    chk({tag, "_valid"}, 32'(key_valid), 32'h0);
    chk({tag, "_digits"}, digits, 32'hAAAA_AAAA);
    rst_n = 1'b1;
  endtask

  initial begin
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;

    // reset state and column rotation with no keys
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(col), 32'h0000_000E);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_held", 32'(key_held), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_digits", digits, 32'hAAAA_AAAA);
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      chk("col_rotate", 32'(col), 32'(pat[(n / 4) % 4]));
    end
    idle_scans(2);
    chk("idle_no_pulse", 32'(pulses), 32'd0);
    chk("idle_digits", digits, 32'hAAAA_AAAA);

    // single key 8
    base = pulses;
    keys[K8] = 1'b1;
    wait_pulse("key8", lat);
    chk("key8_code", 32'(key_code), 32'h8);
    chk("key8_held", 32'(key_held), 32'h1);
    chk("key8_digits", digits, 32'hAAAA_AAA8);
    idle_scans(3);
    chk("key8_single_pulse", 32'(pulses - base), 32'd1);
    keys = 16'h0000;
    idle_scans(4);
    chk("key8_release_held", 32'(key_held), 32'h0);
    chk("key8_code_kept", 32'(key_code), 32'h8);

    // 1, 2, then C clears the display
    do_reset("rst2");
    base = pulses;
    keys[K1] = 1'b1;
    wait_pulse("seq1", lat);
    chk("seq1_digits", digits, 32'hAAAA_AAA1);
    keys = 16'h0000; idle_scans(4);
    keys[K2] = 1'b1;
    wait_pulse("seq2", lat);
    chk("seq2_digits", digits, 32'hAAAA_AA12);
    keys = 16'h0000; idle_scans(4);
    keys[KC] = 1'b1;
    wait_pulse("seqC", lat);
    chk("seqC_code", 32'(key_code), 32'hC);
    chk("seqC_digits", digits, 32'hAAAA_AAAA);
    chk("seq_pulse_count", 32'(pulses - base), 32'd3);
    keys = 16'h0000; idle_scans(4);

    // key 5 bouncing every scan, then held
    base = pulses;
    align_scan();
    for (int s = 0; s < 6; s++) begin
      keys[K5] = (s % 2 == 0);
      repeat (SCAN) @(negedge clk);
    end
    keys[K5] = 1'b1;
    repeat (2) @(negedge clk);
    chk("bounce_no_pulse", 32'(pulses - base), 32'd0);
    wait_pulse("bounce5", lat);
    chk("bounce5_needs_two_scans", 32'(lat > SCAN), 32'd1);
    chk("bounce5_code", 32'(key_code), 32'h5);
    chk("bounce5_digits", digits, 32'hAAAA_AAA5);
    keys = 16'h0000; idle_scans(4);

    // 1 and 6 together, then release 6
    base = pulses;
    keys[K1] = 1'b1; keys[K6] = 1'b1;
    idle_scans(5);
    chk("multi_no_pulse", 32'(pulses - base), 32'd0);
    chk("multi_not_held", 32'(key_held), 32'h0);
    keys[K6] = 1'b0;
    wait_pulse("multi_to_1", lat);
    chk("multi_to_1_code", 32'(key_code), 32'h1);
    chk("multi_to_1_held", 32'(key_held), 32'h1);
    chk("multi_to_1_digits", digits, 32'hAAAA_AA51);
    keys = 16'h0000; idle_scans(4);

    // roll from 3 to 4 locks out; a fresh 4 is accepted
    base = pulses;
    keys[K3] = 1'b1;
    wait_pulse("roll3", lat);
    chk("roll3_code", 32'(key_code), 32'h3);
    chk("roll3_digits", digits, 32'hAAAA_A513);
    keys[K4] = 1'b1;
    idle_scans(1);
    keys[K3] = 1'b0;
    idle_scans(4);
    chk("roll_locked_no_pulse", 32'(pulses - base), 32'd1);
    chk("roll_locked_held", 32'(key_held), 32'h0);
    chk("roll_locked_code", 32'(key_code), 32'h3);
    keys = 16'h0000; idle_scans(4);
    chk("roll_release_no_pulse", 32'(pulses - base), 32'd1);
    keys[K4] = 1'b1;
    wait_pulse("fresh4", lat);
    chk("fresh4_code", 32'(key_code), 32'h4);
    chk("fresh4_digits", digits, 32'hAAAA_5134);
    keys = 16'h0000; idle_scans(4);

    // letter A leaves the display untouched
    keys[KA] = 1'b1;
    wait_pulse("letterA", lat);
    chk("letterA_code", 32'(key_code), 32'hA);
    chk("letterA_digits", digits, 32'hAAAA_5134);
    keys = 16'h0000; idle_scans(4);

    // reset mid-press: full debounce required afterwards
    base = pulses;
    keys[K7] = 1'b1;
    repeat (SCAN) @(negedge clk);
    do_reset("rst_mid");
    wait_pulse("after_rst7", lat);
    chk("after_rst7_full_debounce", 32'(lat >= DS * SCAN), 32'd1);
    chk("after_rst7_code", 32'(key_code), 32'h7);
    chk("after_rst7_digits", digits, 32'hAAAA_AAA7);
    keys = 16'h0000; idle_scans(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
